// File: rtl/mario_kinematics_if.sv
// Player motion bundle between the frame controller and the kinematics engine.
// The controller drives the strobe, the pad levels and the camera edge; the engine returns sprite state.
interface mario_kinematics_if #(
  parameter int unsigned X_W  = 11,
  parameter int unsigned Y_W  = 10,
  parameter int unsigned V_W  = 6,
  parameter int unsigned ID_W = 6
);
  logic                   tick;
  logic                   left;
  logic                   right;
  logic                   jump;
  logic [X_W-1:0]         view;
  logic [X_W-1:0]         mario_x;
  logic [Y_W-1:0]         mario_y;
  logic signed [V_W-1:0]  vel_x;
  logic signed [V_W-1:0]  vel_y;
  logic                   grounded;
  logic                   face_left;
  logic [2:0]             state;
  logic [ID_W-1:0]        mario_id;

  modport master (
    output tick, left, right, jump, view,
    input  mario_x, mario_y, vel_x, vel_y, grounded, face_left, state, mario_id
  );

  modport slave (
    input  tick, left, right, jump, view,
    output mario_x, mario_y, vel_x, vel_y, grounded, face_left, state, mario_id
  );
endinterface

// File: rtl/mario_kinematics.sv
// Per-frame player motion: walk/skid/friction, jump/gravity/jump-cut, window clamping and
// sprite selection. Everything advances only on clk edges where tick is high.
module mario_kinematics #(
  parameter int unsigned X_W      = 11,
  parameter int unsigned Y_W      = 10,
  parameter int unsigned V_W      = 6,
  parameter int unsigned ID_W     = 6,
  parameter int unsigned ACCEL    = 1,
  parameter int unsigned MAX_VX   = 4,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned JUMP_V   = 12,
  parameter int unsigned JUMP_CUT = 3,
  parameter int unsigned MAX_VY   = 8,
  parameter int unsigned GROUND_Y = 400,
  parameter int unsigned X_START  = 32,
  parameter int unsigned X_MAX    = 2000,
  parameter int unsigned ANIM_DIV = 4,
  parameter int unsigned ID_BASE  = 0
) (
  input logic               clk,
  input logic               rst,
  mario_kinematics_if.slave bus
);
  typedef enum logic [2:0] {
    StIdle = 3'd0, StWalk = 3'd1, StSkid = 3'd2, StRise = 3'd3, StFall = 3'd4
  } state_e;

  typedef logic signed [V_W+1:0] vel_t;
  typedef logic signed [X_W+1:0] xpos_t;
  typedef logic signed [Y_W+1:0] ypos_t;

  localparam int unsigned CntW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam vel_t      Accel    = vel_t'(ACCEL);
  localparam vel_t      Accel2   = vel_t'(2 * ACCEL);
  localparam vel_t      MaxVx    = vel_t'(MAX_VX);
  localparam vel_t      Gravity  = vel_t'(GRAVITY);
  localparam vel_t      JumpV    = vel_t'(JUMP_V);
  localparam vel_t      JumpCut  = vel_t'(JUMP_CUT);
  localparam vel_t      MaxVy    = vel_t'(MAX_VY);
  localparam vel_t      One      = vel_t'(1);
  localparam xpos_t     XMax     = xpos_t'(X_MAX);
  localparam ypos_t     GroundY  = ypos_t'(GROUND_Y);
  localparam [CntW-1:0] AnimLast = CntW'(ANIM_DIV - 1);

  logic [X_W-1:0]        x_q, x_n;
  logic [Y_W-1:0]        y_q, y_n;
  logic signed [V_W-1:0] vx_q, vy_q;
  logic                  grounded_q, grounded_n;
  logic                  face_q, face_n;
  logic                  jump_prev_q;
  state_e                state_q, state_n;
  logic [ID_W-1:0]       id_q, id_n, off;
  logic [CntW-1:0]       cnt_q, cnt_n;
  logic [1:0]            frame_q, frame_n;

  vel_t  dir, vx, vy, vx_n, vy_n, step;
  xpos_t x_sum, view_s;
  ypos_t y_sum;
  logic  skid, launch, ceiling;

  always_comb begin
    dir = '0;
    if (bus.right && !bus.left) dir = One;
    else if (bus.left && !bus.right) dir = -One;

    // Horizontal: friction / skid on ground, momentum kept in the air.
    vx   = vel_t'(vx_q);
    skid = grounded_q && (dir != '0) && (vx != '0) && (dir[V_W+1] != vx[V_W+1]);
    step = skid ? Accel2 : Accel;
    if (grounded_q && ((dir == '0) || skid)) begin
      if (vx > step)       vx_n = vx - step;
      else if (vx < -step) vx_n = vx + step;
      else                 vx_n = '0;
    end else if (!grounded_q && (dir == '0)) begin
      vx_n = vx;
    end else begin
      vx_n = dir[V_W+1] ? (vx - Accel) : (vx + Accel);
      if (vx_n > MaxVx)       vx_n = MaxVx;
      else if (vx_n < -MaxVx) vx_n = -MaxVx;
    end

    view_s = $signed({2'b00, bus.view});
    x_sum  = $signed({2'b00, x_q}) + xpos_t'(vx_n);
    // Camera edge takes priority, even when it lies beyond the world edge.
    if ((x_sum < view_s) || (view_s > XMax)) begin
      x_n  = bus.view;
      vx_n = '0;
    end else if (x_sum > XMax) begin
      x_n  = X_W'(X_MAX);
      vx_n = '0;
    end else begin
      x_n = x_sum[X_W-1:0];
    end

    launch     = grounded_q && bus.jump && !jump_prev_q;
    vy         = vel_t'(vy_q);
    vy_n       = '0;
    y_n        = y_q;
    y_sum      = '0;
    grounded_n = grounded_q;
    ceiling    = 1'b0;
    if (launch) begin
      vy_n       = -JumpV;
      y_n        = y_q - Y_W'(JUMP_V);
      grounded_n = 1'b0;
    end else if (!grounded_q) begin
      vy_n = (state_q == StRise && !bus.jump && vy < -JumpCut) ? -JumpCut : vy;
      vy_n = vy_n + Gravity;
      if (vy_n > MaxVy) vy_n = MaxVy;
      y_sum = $signed({2'b00, y_q}) + ypos_t'(vy_n);
      if (y_sum >= GroundY) begin
        y_n        = Y_W'(GROUND_Y);
        vy_n       = '0;
        grounded_n = 1'b1;
      end else if (y_sum[Y_W+1]) begin
        y_n     = '0;
        vy_n    = '0;
        ceiling = 1'b1;
      end else begin
        y_n = y_sum[Y_W-1:0];
      end
    end

    if (grounded_n) begin
      if (skid)                             state_n = StSkid;
      else if ((vx_n != '0) || (dir != '0)) state_n = StWalk;
      else                                  state_n = StIdle;
    end else if (launch) begin
      state_n = StRise;
    end else if (ceiling || (state_q == StRise && !vy_n[V_W+1])) begin
      state_n = StFall;
    end else begin
      state_n = state_q;
    end

    face_n = (grounded_q && (dir != '0)) ? dir[V_W+1] : face_q;

    // Walk cycle restarts at its first frame whenever WALK is (re)entered.
    cnt_n   = '0;
    frame_n = '0;
    if (state_n == StWalk && state_q == StWalk) begin
      if (cnt_q == AnimLast) begin
        frame_n = (frame_q == 2'd2) ? 2'd0 : 2'(frame_q + 2'd1);
      end else begin
        cnt_n   = CntW'(cnt_q + 1'b1);
        frame_n = frame_q;
      end
    end

    case (state_n)
      StIdle:  off = '0;
      StWalk:  off = ID_W'(1) + ID_W'(frame_n);
      StSkid:  off = ID_W'(4);
      default: off = ID_W'(5);
    endcase
    id_n = ID_W'(ID_BASE) + off + (face_n ? ID_W'(8) : ID_W'(0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= X_W'(X_START);
      y_q         <= Y_W'(GROUND_Y);
      vx_q        <= '0;
      vy_q        <= '0;
      grounded_q  <= 1'b1;
      face_q      <= 1'b0;
      jump_prev_q <= 1'b1;
      state_q     <= StIdle;
      id_q        <= ID_W'(ID_BASE);
      cnt_q       <= '0;
      frame_q     <= '0;
    end else if (bus.tick) begin
      x_q         <= x_n;
      y_q         <= y_n;
      vx_q        <= vx_n[V_W-1:0];
      vy_q        <= vy_n[V_W-1:0];
      grounded_q  <= grounded_n;
      face_q      <= face_n;
      jump_prev_q <= bus.jump;
      state_q     <= state_n;
      id_q        <= id_n;
      cnt_q       <= cnt_n;
      frame_q     <= frame_n;
    end
  end

  assign bus.mario_x   = x_q;
  assign bus.mario_y   = y_q;
  assign bus.vel_x     = vx_q;
  assign bus.vel_y     = vy_q;
  assign bus.grounded  = grounded_q;
  assign bus.face_left = face_q;
  assign bus.state     = state_q;
  assign bus.mario_id  = id_q;
endmodule

// File: tb/tb_mario_kinematics.sv
// Directed bench for mario_kinematics: walk, skid, window clamps, jump arc, jump cut
// and asynchronous reset, with hand-computed expectations.
module tb_mario_kinematics;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   total = 0;

  always #5 clk = ~clk;

  mario_kinematics_if bus ();
  mario_kinematics dut (.clk(clk), .rst(rst), .bus(bus));

  // n consecutive tick cycles (back-to-back when n > 1); returns on a negedge.
  task automatic pulse_ticks(input int n);
    @(negedge clk);
    bus.tick = 1'b1;
    repeat (n) @(negedge clk);
    bus.tick = 1'b0;
  endtask

  task automatic do_reset(input logic r, input logic l, input logic j);
    @(negedge clk);
    bus.right = r; bus.left = l; bus.jump = j; bus.view = '0; bus.tick = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.right = 1'b1; bus.left = 1'b0; bus.jump = 1'b1; bus.view = '0; bus.tick = 1'b0;
    rst = 1'b1;
    #3;
    total++;
    if (bus.mario_x !== 11'd32 || bus.mario_y !== 10'd400 || bus.vel_x !== 6'd0 ||
        bus.vel_y !== 6'd0 || bus.grounded !== 1'b1 || bus.face_left !== 1'b0 ||
        bus.state !== 3'd0 || bus.mario_id !== 6'd0)
      $display("FAIL reset_values: x=%0d y=%0d vx=%0d vy=%0d g=%b f=%b st=%0d id=%0d want 32 400 0 0 1 0 0 0",
               bus.mario_x, bus.mario_y, $signed(bus.vel_x), $signed(bus.vel_y), bus.grounded,
               bus.face_left, bus.state, bus.mario_id);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.mario_x !== 11'd32 || bus.vel_x !== 6'd0 || bus.state !== 3'd0)
      $display("FAIL hold_without_tick: x=%0d vx=%0d st=%0d want 32 0 0",
               bus.mario_x, $signed(bus.vel_x), bus.state);
    else pass_cnt++;
  endtask

  task automatic test_walk();
    int wx[5]  = '{33, 35, 38, 42, 46};
    int wvx[5] = '{1, 2, 3, 4, 4};
    int wid[5] = '{1, 1, 1, 1, 2};
    for (int i = 0; i < 5; i++) begin
      pulse_ticks(1);
      total++;
      if (bus.mario_x !== 11'(wx[i]) || $signed(bus.vel_x) !== wvx[i] || bus.state !== 3'd1 ||
          bus.face_left !== 1'b0 || bus.grounded !== 1'b1 || bus.mario_y !== 10'd400 ||
          bus.mario_id !== 6'(wid[i]))
        $display("FAIL walk_t%0d: x=%0d vx=%0d st=%0d f=%b g=%b y=%0d id=%0d want x=%0d vx=%0d st=1 f=0 g=1 y=400 id=%0d",
                 i + 1, bus.mario_x, $signed(bus.vel_x), bus.state, bus.face_left, bus.grounded,
                 bus.mario_y, bus.mario_id, wx[i], wvx[i], wid[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_skid();
    int wx[3]  = '{48, 48, 47};
    int wvx[3] = '{2, 0, -1};
    int ws[3]  = '{2, 2, 1};
    int wid[3] = '{12, 12, 9};
    bus.right = 1'b0; bus.left = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse_ticks(1);
      total++;
      if (bus.mario_x !== 11'(wx[i]) || $signed(bus.vel_x) !== wvx[i] ||
          bus.state !== 3'(ws[i]) || bus.mario_id !== 6'(wid[i]) || bus.face_left !== 1'b1)
        $display("FAIL skid_t%0d: x=%0d vx=%0d st=%0d id=%0d f=%b want x=%0d vx=%0d st=%0d id=%0d f=1",
                 i + 1, bus.mario_x, $signed(bus.vel_x), bus.state, bus.mario_id, bus.face_left,
                 wx[i], wvx[i], ws[i], wid[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_view_clamp();
    do_reset(1'b1, 1'b0, 1'b0);
    pulse_ticks(21);
    total++;
    if (bus.mario_x !== 11'd110 || $signed(bus.vel_x) !== 4)
      $display("FAIL run_right: x=%0d vx=%0d want 110 4", bus.mario_x, $signed(bus.vel_x));
    else pass_cnt++;
    bus.right = 1'b0; bus.left = 1'b1;
    pulse_ticks(6);
    total++;
    if (bus.mario_x !== 11'd102 || $signed(bus.vel_x) !== -4)
      $display("FAIL run_left: x=%0d vx=%0d want 102 -4", bus.mario_x, $signed(bus.vel_x));
    else pass_cnt++;
    bus.view = 11'd100;
    pulse_ticks(1);
    total++;
    if (bus.mario_x !== 11'd100 || bus.vel_x !== 6'd0 || bus.state !== 3'd1)
      $display("FAIL view_clamp: x=%0d vx=%0d st=%0d want 100 0 1",
               bus.mario_x, $signed(bus.vel_x), bus.state);
    else pass_cnt++;
    pulse_ticks(1);
    total++;
    if (bus.mario_x !== 11'd100 || bus.vel_x !== 6'd0)
      $display("FAIL view_hold: x=%0d vx=%0d want 100 0", bus.mario_x, $signed(bus.vel_x));
    else pass_cnt++;
  endtask

  task automatic test_xmax_clamp();
    bus.left = 1'b0; bus.right = 1'b1;
    pulse_ticks(476);
    total++;
    if (bus.mario_x !== 11'd1998 || $signed(bus.vel_x) !== 4)
      $display("FAIL near_xmax: x=%0d vx=%0d want 1998 4", bus.mario_x, $signed(bus.vel_x));
    else pass_cnt++;
    pulse_ticks(1);
    total++;
    if (bus.mario_x !== 11'd2000 || bus.vel_x !== 6'd0)
      $display("FAIL xmax_clamp: x=%0d vx=%0d want 2000 0", bus.mario_x, $signed(bus.vel_x));
    else pass_cnt++;
    pulse_ticks(1);
    total++;
    if (bus.mario_x !== 11'd2000 || bus.vel_x !== 6'd0)
      $display("FAIL xmax_hold: x=%0d vx=%0d want 2000 0", bus.mario_x, $signed(bus.vel_x));
    else pass_cnt++;
    bus.view = 11'd2040;
    pulse_ticks(1);
    total++;
    if (bus.mario_x !== 11'd2040 || bus.vel_x !== 6'd0)
      $display("FAIL view_over_xmax: x=%0d vx=%0d want 2040 0", bus.mario_x, $signed(bus.vel_x));
    else pass_cnt++;
  endtask

  task automatic test_jump();
    int ry[12]  = '{377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322, 322};
    int fy[14]  = '{323, 325, 328, 332, 337, 343, 350, 358, 366, 374, 382, 390, 398, 400};
    int fvy[14] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8, 8, 8, 8, 0};
    do_reset(1'b0, 1'b0, 1'b0);
    pulse_ticks(1);
    bus.jump = 1'b1;
    pulse_ticks(1);
    total++;
    if ($signed(bus.vel_y) !== -12 || bus.mario_y !== 10'd388 || bus.state !== 3'd3 ||
        bus.grounded !== 1'b0 || bus.mario_id !== 6'd5)
      $display("FAIL launch: vy=%0d y=%0d st=%0d g=%b id=%0d want -12 388 3 0 5",
               $signed(bus.vel_y), bus.mario_y, bus.state, bus.grounded, bus.mario_id);
    else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      pulse_ticks(1);
      total++;
      if ($signed(bus.vel_y) !== i - 11 || bus.mario_y !== 10'(ry[i]) ||
          bus.state !== ((i == 11) ? 3'd4 : 3'd3))
        $display("FAIL rise_t%0d: vy=%0d y=%0d st=%0d want vy=%0d y=%0d st=%0d",
                 i + 2, $signed(bus.vel_y), bus.mario_y, bus.state, i - 11, ry[i],
                 (i == 11) ? 4 : 3);
      else pass_cnt++;
    end
    for (int i = 0; i < 14; i++) begin
      pulse_ticks(1);
      total++;
      if ($signed(bus.vel_y) !== fvy[i] || bus.mario_y !== 10'(fy[i]) ||
          bus.state !== ((i == 13) ? 3'd0 : 3'd4) || bus.grounded !== (i == 13))
        $display("FAIL fall_t%0d: vy=%0d y=%0d st=%0d g=%b want vy=%0d y=%0d st=%0d g=%b",
                 i + 1, $signed(bus.vel_y), bus.mario_y, bus.state, bus.grounded, fvy[i], fy[i],
                 (i == 13) ? 0 : 4, i == 13);
      else pass_cnt++;
    end
    pulse_ticks(1);
    total++;
    if (bus.grounded !== 1'b1 || bus.mario_y !== 10'd400 || bus.state !== 3'd0 ||
        bus.mario_id !== 6'd0)
      $display("FAIL no_rejump_held: g=%b y=%0d st=%0d id=%0d want 1 400 0 0",
               bus.grounded, bus.mario_y, bus.state, bus.mario_id);
    else pass_cnt++;
  endtask

  task automatic test_jump_cut();
    int wvy[3] = '{-2, -1, 0};
    int wy[3]  = '{386, 385, 385};
    int ws[3]  = '{3, 3, 4};
    bus.jump = 1'b0;
    pulse_ticks(1);
    bus.jump = 1'b1;
    pulse_ticks(1);
    bus.jump = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse_ticks(1);
      total++;
      if ($signed(bus.vel_y) !== wvy[i] || bus.mario_y !== 10'(wy[i]) ||
          bus.state !== 3'(ws[i]))
        $display("FAIL jump_cut_t%0d: vy=%0d y=%0d st=%0d want vy=%0d y=%0d st=%0d",
                 i + 1, $signed(bus.vel_y), bus.mario_y, bus.state, wvy[i], wy[i], ws[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1, 1'b0, 1'b0);
    pulse_ticks(1);
    bus.jump = 1'b1;
    pulse_ticks(4);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.mario_x !== 11'd32 || bus.mario_y !== 10'd400 || bus.vel_y !== 6'd0 ||
        bus.vel_x !== 6'd0 || bus.grounded !== 1'b1 || bus.state !== 3'd0 ||
        bus.mario_id !== 6'd0)
      $display("FAIL async_reset: x=%0d y=%0d vx=%0d vy=%0d g=%b st=%0d id=%0d want 32 400 0 0 1 0 0",
               bus.mario_x, bus.mario_y, $signed(bus.vel_x), $signed(bus.vel_y), bus.grounded,
               bus.state, bus.mario_id);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulse_ticks(1);
    total++;
    if (bus.grounded !== 1'b1 || bus.state !== 3'd1 || bus.mario_x !== 11'd33 ||
        bus.mario_y !== 10'd400)
      $display("FAIL resume_after_reset: g=%b st=%0d x=%0d y=%0d want 1 1 33 400",
               bus.grounded, bus.state, bus.mario_x, bus.mario_y);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_walk();
    test_skid();
    test_view_clamp();
    test_xmax_clamp();
    test_jump();
    test_jump_cut();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
